audio_track_ctrl: RTL and testbench

Parametrised record/play control FSM for the WM8731 audio path. It sits between the user keys and the I2C initializer, recorder, DSP and player. It generalises single-take control to NUM_TRACKS independent SRAM regions, with per-track end addresses, valid flags and an auto-stop at each region limit. It also drives the SRAM direction and address-mux selects.

---
 rtl/audio_track_ctrl.sv | 273 +++++++++++++++++++++++++++
 tb/tb_audio_track_ctrl.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_track_ctrl.sv
// Record/play control FSM for a multi-track WM8731 audio path over NUM_TRACKS equal SRAM regions.
// Optional macro AUDIO_TRACK_LOOP_EN: loop the active track at its end instead of returning to IDLE.
module audio_track_ctrl #(
    parameter int ADDR_W     = 20,
    parameter int NUM_TRACKS = 4,
    localparam int TRK_W     = $clog2(NUM_TRACKS)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_init_done,
    input  logic                  i_key_rec,
    input  logic                  i_key_play,
    input  logic                  i_key_stop,
    input  logic [TRK_W-1:0]      i_track_sel,
    input  logic [ADDR_W-1:0]     i_rec_addr,
    input  logic [ADDR_W-1:0]     i_play_addr,
    output logic                  o_i2c_start,
    output logic                  o_rec_start,
    output logic                  o_rec_pause,
    output logic                  o_rec_stop,
    output logic                  o_play_start,
    output logic                  o_play_pause,
    output logic                  o_play_stop,
    output logic                  o_player_en,
    output logic                  o_sram_we_n,
    output logic                  o_rec_sel,
    output logic [ADDR_W-1:0]     o_track_base,
    output logic [ADDR_W-1:0]     o_track_end,
    output logic [NUM_TRACKS-1:0] o_track_valid,
    output logic [2:0]            o_state
);

    typedef enum logic [2:0] {
        S_INIT       = 3'd0,
        S_IDLE       = 3'd1,
        S_RECD       = 3'd2,
        S_RECD_PAUSE = 3'd3,
        S_PLAY       = 3'd4,
        S_PLAY_PAUSE = 3'd5
    } state_t;

    localparam int LOW_W = ADDR_W - TRK_W;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [TRK_W-1:0]      r_active_track;
    logic [TRK_W-1:0]      w_active_nxt;
    logic [ADDR_W-1:0]     r_end [NUM_TRACKS];
    logic [NUM_TRACKS-1:0] r_valid;
    logic [NUM_TRACKS-1:0] w_valid_nxt;
    logic                  w_commit;
    logic                  w_key_stop;
    logic                  w_key_rec;
    logic                  w_key_play;
    logic [ADDR_W-1:0]     w_track_limit;
    logic                  w_rec_start;
    logic                  w_rec_pause;
    logic                  w_rec_stop;
    logic                  w_play_start;
    logic                  w_play_pause;
    logic                  w_play_stop;
    logic                  r_rec_start;
    logic                  r_rec_pause;
    logic                  r_rec_stop;
    logic                  r_play_start;
    logic                  r_play_pause;
    logic                  r_play_stop;
    logic                  r_i2c_start;
    logic                  r_player_en;
    logic                  r_sram_we_n;
    logic                  r_rec_sel;
    logic [ADDR_W-1:0]     r_track_base;
    logic [ADDR_W-1:0]     r_track_end;
`ifdef AUDIO_TRACK_LOOP_EN
    logic                  r_loop_pend;
    logic                  w_loop_pend_nxt;
`endif

    // Key priority stop > rec > play; lower keys pressed together are dropped.
    assign w_key_stop = i_key_stop;
    assign w_key_rec  = i_key_rec & ~i_key_stop;
    assign w_key_play = i_key_play & ~i_key_stop & ~i_key_rec;

    // Last word of the active region; the low bits saturate so it never crosses into the next track.
    assign w_track_limit = {r_active_track, {LOW_W{1'b1}}};

    // Next-state, track bookkeeping and command-pulse decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_active_nxt = r_active_track;
        w_valid_nxt  = r_valid;
        w_commit     = 1'b0;
        w_rec_start  = 1'b0;
        w_rec_pause  = 1'b0;
        w_rec_stop   = 1'b0;
        w_play_start = 1'b0;
        w_play_pause = 1'b0;
        w_play_stop  = 1'b0;
`ifdef AUDIO_TRACK_LOOP_EN
        w_loop_pend_nxt = 1'b0;
`endif
        case (r_state)
            S_INIT: begin
                if (i_init_done) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_INIT;
                end
            end
            S_IDLE: begin
                if (w_key_rec) begin
                    w_active_nxt             = i_track_sel;
                    w_valid_nxt[i_track_sel] = 1'b0;
                    w_rec_start              = 1'b1;
                    w_state_nxt              = S_RECD;
                end else if (w_key_play && r_valid[i_track_sel]) begin
                    w_active_nxt = i_track_sel;
                    w_play_start = 1'b1;
                    w_state_nxt  = S_PLAY;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RECD: begin
                if (w_key_rec) begin
                    w_rec_pause = 1'b1;
                    w_state_nxt = S_RECD_PAUSE;
                end else if (w_key_stop || (i_rec_addr == w_track_limit)) begin
                    w_commit                    = 1'b1;
                    w_valid_nxt[r_active_track] = (i_rec_addr != r_track_base);
                    w_rec_stop                  = 1'b1;
                    w_state_nxt                 = S_IDLE;
                end else begin
                    w_state_nxt = S_RECD;
                end
            end
            S_RECD_PAUSE: begin
                // Resume re-uses the pause toggle; the recorder keeps its write pointer.
                if (w_key_rec) begin
                    w_rec_pause = 1'b1;
                    w_state_nxt = S_RECD;
                end else if (w_key_stop) begin
                    w_commit                    = 1'b1;
                    w_valid_nxt[r_active_track] = (i_rec_addr != r_track_base);
                    w_rec_stop                  = 1'b1;
                    w_state_nxt                 = S_IDLE;
                end else begin
                    w_state_nxt = S_RECD_PAUSE;
                end
            end
            S_PLAY: begin
                if (w_key_play) begin
                    w_play_pause = 1'b1;
                    w_state_nxt  = S_PLAY_PAUSE;
                end else if (w_key_stop) begin
                    w_play_stop = 1'b1;
                    w_state_nxt = S_IDLE;
`ifdef AUDIO_TRACK_LOOP_EN
                end else if (r_loop_pend) begin
                    w_play_start = 1'b1;
                    w_state_nxt  = S_PLAY;
                end else if (i_play_addr >= r_track_end) begin
                    w_play_stop     = 1'b1;
                    w_loop_pend_nxt = 1'b1;
                    w_state_nxt     = S_PLAY;
`else
                end else if (i_play_addr >= r_track_end) begin
                    w_play_stop = 1'b1;
                    w_state_nxt = S_IDLE;
`endif
                end else begin
                    w_state_nxt = S_PLAY;
                end
            end
            S_PLAY_PAUSE: begin
                if (w_key_play) begin
                    w_play_pause = 1'b1;
                    w_state_nxt  = S_PLAY;
                end else if (w_key_stop) begin
                    w_play_stop = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_PLAY_PAUSE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, active track and valid flags.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= S_INIT;
            r_active_track <= {TRK_W{1'b0}};
            r_valid        <= {NUM_TRACKS{1'b0}};
        end else begin
            r_state        <= w_state_nxt;
            r_active_track <= w_active_nxt;
            r_valid        <= w_valid_nxt;
        end
    end

    // Per-track end addresses, written only on commit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_TRACKS; i++) begin
                r_end[i] <= {ADDR_W{1'b0}};
            end
        end else if (w_commit) begin
            r_end[r_active_track] <= i_rec_addr;
        end
    end

`ifdef AUDIO_TRACK_LOOP_EN
    // Restart request held for one cycle between the loop stop and start pulses.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_loop_pend <= 1'b0;
        end else begin
            r_loop_pend <= w_loop_pend_nxt;
        end
    end
`endif

    // Registered command pulses and state-decoded levels, aligned with the new state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rec_start  <= 1'b0;
            r_rec_pause  <= 1'b0;
            r_rec_stop   <= 1'b0;
            r_play_start <= 1'b0;
            r_play_pause <= 1'b0;
            r_play_stop  <= 1'b0;
            r_i2c_start  <= 1'b1;
            r_player_en  <= 1'b0;
            r_sram_we_n  <= 1'b1;
            r_rec_sel    <= 1'b0;
            r_track_base <= {ADDR_W{1'b0}};
            r_track_end  <= {ADDR_W{1'b0}};
        end else begin
            r_rec_start  <= w_rec_start;
            r_rec_pause  <= w_rec_pause;
            r_rec_stop   <= w_rec_stop;
            r_play_start <= w_play_start;
            r_play_pause <= w_play_pause;
            r_play_stop  <= w_play_stop;
            r_i2c_start  <= (w_state_nxt == S_INIT);
            r_player_en  <= (w_state_nxt == S_PLAY);
            r_sram_we_n  <= (w_state_nxt != S_RECD);
            r_rec_sel    <= (w_state_nxt == S_RECD);
            r_track_base <= {w_active_nxt, {LOW_W{1'b0}}};
            r_track_end  <= w_commit ? i_rec_addr : r_end[w_active_nxt];
        end
    end

    assign o_i2c_start   = r_i2c_start;
    assign o_rec_start   = r_rec_start;
    assign o_rec_pause   = r_rec_pause;
    assign o_rec_stop    = r_rec_stop;
    assign o_play_start  = r_play_start;
    assign o_play_pause  = r_play_pause;
    assign o_play_stop   = r_play_stop;
    assign o_player_en   = r_player_en;
    assign o_sram_we_n   = r_sram_we_n;
    assign o_rec_sel     = r_rec_sel;
    assign o_track_base  = r_track_base;
    assign o_track_end   = r_track_end;
    assign o_track_valid = r_valid;
    assign o_state       = r_state;

endmodule

// File: tb/tb_audio_track_ctrl.sv
// Self-checking bench for audio_track_ctrl: directed scenarios plus randomized keys/addresses
// checked against a behavioural model of the track controller.
module tb_audio_track_ctrl;

    localparam logic [19:0] REGION = 20'h40000;
`ifdef AUDIO_TRACK_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        init_done = 1'b0;
    logic        key_rec   = 1'b0;
    logic        key_play  = 1'b0;
    logic        key_stop  = 1'b0;
    logic [1:0]  track_sel = 2'd0;
    logic [19:0] rec_addr  = 20'd0;
    logic [19:0] play_addr = 20'd0;

    logic        o_i2c_start, o_rec_start, o_rec_pause, o_rec_stop;
    logic        o_play_start, o_play_pause, o_play_stop;
    logic        o_player_en, o_sram_we_n, o_rec_sel;
    logic [19:0] o_track_base, o_track_end;
    logic [3:0]  o_track_valid;
    logic [2:0]  o_state;
    logic [56:0] obs;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model: state name as an int code, track table as arrays.
    int          m_state;
    int          m_active;
    logic [19:0] m_end [4];
    logic [3:0]  m_valid;
    bit          m_pend;
    bit          e_rs, e_rp, e_rst, e_ps, e_pp, e_pst;

    audio_track_ctrl dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_init_done  (init_done),
        .i_key_rec    (key_rec),
        .i_key_play   (key_play),
        .i_key_stop   (key_stop),
        .i_track_sel  (track_sel),
        .i_rec_addr   (rec_addr),
        .i_play_addr  (play_addr),
        .o_i2c_start  (o_i2c_start),
        .o_rec_start  (o_rec_start),
        .o_rec_pause  (o_rec_pause),
        .o_rec_stop   (o_rec_stop),
        .o_play_start (o_play_start),
        .o_play_pause (o_play_pause),
        .o_play_stop  (o_play_stop),
        .o_player_en  (o_player_en),
        .o_sram_we_n  (o_sram_we_n),
        .o_rec_sel    (o_rec_sel),
        .o_track_base (o_track_base),
        .o_track_end  (o_track_end),
        .o_track_valid(o_track_valid),
        .o_state      (o_state)
    );

    always #5 clk = ~clk;

    assign obs = {o_state, o_rec_start, o_rec_pause, o_rec_stop, o_play_start, o_play_pause,
                  o_play_stop, o_i2c_start, o_player_en, o_sram_we_n, o_rec_sel,
                  o_track_base, o_track_end, o_track_valid};

    function automatic logic [56:0] exp_vec();
        logic [19:0] b;
        b = 20'(m_active) * REGION;
        return {3'(m_state), e_rs, e_rp, e_rst, e_ps, e_pp, e_pst,
                (m_state == 0), (m_state == 4), (m_state != 2), (m_state == 2),
                b, m_end[m_active], m_valid};
    endfunction

    task automatic model_reset();
        m_state  = 0;
        m_active = 0;
        for (int i = 0; i < 4; i++) m_end[i] = 20'd0;
        m_valid  = 4'b0000;
        m_pend   = 1'b0;
        {e_rs, e_rp, e_rst, e_ps, e_pp, e_pst} = 6'b000000;
    endtask

    task automatic model_commit();
        logic [19:0] b;
        b = 20'(m_active) * REGION;
        m_end[m_active]   = rec_addr;
        m_valid[m_active] = (rec_addr != b);
        e_rst   = 1'b1;
        m_state = 1;
    endtask

    task automatic model_step();
        bit ks, kr, kp, pend_now;
        logic [19:0] lim;
        ks  = key_stop;
        kr  = key_rec && !key_stop;
        kp  = key_play && !key_stop && !key_rec;
        lim = 20'(m_active) * REGION + (REGION - 20'd1);
        {e_rs, e_rp, e_rst, e_ps, e_pp, e_pst} = 6'b000000;
        pend_now = m_pend;
        m_pend   = 1'b0;
        case (m_state)
            0: if (init_done) m_state = 1;
            1: begin
                if (kr) begin
                    m_active = int'(track_sel); m_valid[track_sel] = 1'b0; e_rs = 1'b1; m_state = 2;
                end else if (kp && m_valid[track_sel]) begin
                    m_active = int'(track_sel); e_ps = 1'b1; m_state = 4;
                end
            end
            2: begin
                if (kr) begin e_rp = 1'b1; m_state = 3; end
                else if (ks || rec_addr == lim) model_commit();
            end
            3: begin
                if (kr) begin e_rp = 1'b1; m_state = 2; end
                else if (ks) model_commit();
            end
            4: begin
                if (kp) begin e_pp = 1'b1; m_state = 5; end
                else if (ks) begin e_pst = 1'b1; m_state = 1; end
                else if (LOOP && pend_now) e_ps = 1'b1;
                else if (play_addr >= m_end[m_active]) begin
                    e_pst = 1'b1;
                    if (LOOP) m_pend = 1'b1;
                    else m_state = 1;
                end
            end
            5: begin
                if (kp) begin e_pp = 1'b1; m_state = 4; end
                else if (ks) begin e_pst = 1'b1; m_state = 1; end
            end
            default: m_state = 1;
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        key_rec  = 1'b0;
        key_play = 1'b0;
        key_stop = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        if ({o_state, o_i2c_start, o_sram_we_n, o_rec_sel, o_player_en, o_track_valid} !== {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000}) begin
            $display("FAIL reset_levels: got %b want %b", {o_state, o_i2c_start, o_sram_we_n, o_rec_sel, o_player_en, o_track_valid}, {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000});
            n_fail++;
        end
        n_cmp++;
        if (obs !== exp_vec()) begin
            $display("FAIL reset_vec: got %h want %h", obs, exp_vec()); n_fail++;
        end
        n_cmp++;
        rst = 1'b0;
    endtask

    task automatic test_init();
        for (int i = 0; i < 4; i++) begin
            key_rec = 1'b1; key_play = 1'b1; track_sel = 2'(i);
            step();
            if ({o_state, o_rec_start, o_i2c_start} !== {3'd0, 1'b0, 1'b1}) begin
                $display("FAIL init_hold: got %b want %b", {o_state, o_rec_start, o_i2c_start}, {3'd0, 1'b0, 1'b1}); n_fail++;
            end
            n_cmp++;
        end
        init_done = 1'b1;
        step();
        if ({o_state, o_i2c_start} !== {3'd1, 1'b0}) begin
            $display("FAIL init_done: got %b want %b", {o_state, o_i2c_start}, {3'd1, 1'b0}); n_fail++;
        end
        n_cmp++;
    endtask

    task automatic test_record_stop();
        track_sel = 2'd2; key_rec = 1'b1;
        step();
        if ({o_state, o_rec_start, o_sram_we_n, o_rec_sel, o_track_base} !== {3'd2, 1'b1, 1'b0, 1'b1, 20'h80000}) begin
            $display("FAIL rec_start: got %h want %h", {o_state, o_rec_start, o_sram_we_n, o_rec_sel, o_track_base}, {3'd2, 1'b1, 1'b0, 1'b1, 20'h80000}); n_fail++;
        end
        n_cmp++;
        rec_addr = 20'h80100;
        step();
        if (obs !== exp_vec()) begin
            $display("FAIL rec_hold_vec: got %h want %h", obs, exp_vec()); n_fail++;
        end
        n_cmp++;
        key_rec = 1'b1;
        step();
        if ({o_state, o_rec_pause, o_sram_we_n} !== {3'd3, 1'b1, 1'b1}) begin
            $display("FAIL rec_pause: got %b want %b", {o_state, o_rec_pause, o_sram_we_n}, {3'd3, 1'b1, 1'b1}); n_fail++;
        end
        n_cmp++;
        key_rec = 1'b1;
        step();
        if ({o_state, o_rec_pause, o_rec_start} !== {3'd2, 1'b1, 1'b0}) begin
            $display("FAIL rec_resume: got %b want %b", {o_state, o_rec_pause, o_rec_start}, {3'd2, 1'b1, 1'b0}); n_fail++;
        end
        n_cmp++;
        key_stop = 1'b1;
        step();
        if ({o_state, o_rec_stop, o_track_end, o_track_valid} !== {3'd1, 1'b1, 20'h80100, 4'b0100}) begin
            $display("FAIL rec_commit: got %h want %h", {o_state, o_rec_stop, o_track_end, o_track_valid}, {3'd1, 1'b1, 20'h80100, 4'b0100}); n_fail++;
        end
        n_cmp++;
        step();
        if (obs !== exp_vec() || o_rec_stop !== 1'b0) begin
            $display("FAIL rec_stop_width: got %h want %h", obs, exp_vec()); n_fail++;
        end
        n_cmp++;
    endtask

    task automatic test_autostop();
        track_sel = 2'd1; key_rec = 1'b1;
        step();
        for (int a = 20'h7FFF8; a < 20'h7FFFF; a++) begin
            rec_addr = 20'(a);
            step();
            if (o_state !== 3'd2) begin
                $display("FAIL auto_early: got %0d want %0d", o_state, 2); n_fail++;
            end
            n_cmp++;
        end
        rec_addr = 20'h7FFFF;
        step();
        if ({o_state, o_rec_stop, o_track_end, o_track_valid} !== {3'd1, 1'b1, 20'h7FFFF, 4'b0110}) begin
            $display("FAIL auto_stop: got %h want %h", {o_state, o_rec_stop, o_track_end, o_track_valid}, {3'd1, 1'b1, 20'h7FFFF, 4'b0110}); n_fail++;
        end
        n_cmp++;
    endtask

    task automatic test_play();
        track_sel = 2'd3; key_play = 1'b1;
        step();
        if ({o_state, o_play_start} !== {3'd1, 1'b0}) begin
            $display("FAIL play_invalid: got %b want %b", {o_state, o_play_start}, {3'd1, 1'b0}); n_fail++;
        end
        n_cmp++;
        track_sel = 2'd2; key_play = 1'b1;
        step();
        if ({o_state, o_play_start, o_player_en, o_track_end} !== {3'd4, 1'b1, 1'b1, 20'h80100}) begin
            $display("FAIL play_start: got %h want %h", {o_state, o_play_start, o_player_en, o_track_end}, {3'd4, 1'b1, 1'b1, 20'h80100}); n_fail++;
        end
        n_cmp++;
        play_addr = 20'h80050;
        step();
        key_play = 1'b1;
        step();
        if ({o_state, o_play_pause, o_player_en} !== {3'd5, 1'b1, 1'b0}) begin
            $display("FAIL play_pause: got %b want %b", {o_state, o_play_pause, o_player_en}, {3'd5, 1'b1, 1'b0}); n_fail++;
        end
        n_cmp++;
        key_play = 1'b1;
        step();
        if ({o_state, o_play_pause, o_play_start} !== {3'd4, 1'b1, 1'b0}) begin
            $display("FAIL play_resume: got %b want %b", {o_state, o_play_pause, o_play_start}, {3'd4, 1'b1, 1'b0}); n_fail++;
        end
        n_cmp++;
        play_addr = 20'h80100;
        step();
`ifdef AUDIO_TRACK_LOOP_EN
        if ({o_state, o_play_stop, o_play_start} !== {3'd4, 1'b1, 1'b0}) begin
            $display("FAIL loop_stop: got %b want %b", {o_state, o_play_stop, o_play_start}, {3'd4, 1'b1, 1'b0}); n_fail++;
        end
        n_cmp++;
        play_addr = 20'h80000;
        step();
        if ({o_state, o_play_stop, o_play_start} !== {3'd4, 1'b0, 1'b1}) begin
            $display("FAIL loop_start: got %b want %b", {o_state, o_play_stop, o_play_start}, {3'd4, 1'b0, 1'b1}); n_fail++;
        end
        n_cmp++;
        key_stop = 1'b1;
        step();
`endif
        if ({o_state, o_play_stop, o_player_en} !== {3'd1, 1'b1, 1'b0}) begin
            $display("FAIL play_end: got %b want %b", {o_state, o_play_stop, o_player_en}, {3'd1, 1'b1, 1'b0}); n_fail++;
        end
        n_cmp++;
        if (obs !== exp_vec()) begin
            $display("FAIL play_vec: got %h want %h", obs, exp_vec()); n_fail++;
        end
        n_cmp++;
    endtask

    task automatic test_simultaneous();
        track_sel = 2'd0; key_rec = 1'b1; key_stop = 1'b1;
        step();
        if ({o_state, o_rec_start, o_rec_stop} !== {3'd1, 1'b0, 1'b0}) begin
            $display("FAIL stop_beats_rec: got %b want %b", {o_state, o_rec_start, o_rec_stop}, {3'd1, 1'b0, 1'b0}); n_fail++;
        end
        n_cmp++;
        key_rec = 1'b1; key_play = 1'b1;
        step();
        if ({o_state, o_rec_start, o_play_start} !== {3'd2, 1'b1, 1'b0}) begin
            $display("FAIL rec_beats_play: got %b want %b", {o_state, o_rec_start, o_play_start}, {3'd2, 1'b1, 1'b0}); n_fail++;
        end
        n_cmp++;
        rec_addr = 20'h00000; key_stop = 1'b1;
        step();
        if ({o_state, o_rec_stop, o_track_valid} !== {3'd1, 1'b1, 4'b0110}) begin
            $display("FAIL empty_take: got %b want %b", {o_state, o_rec_stop, o_track_valid}, {3'd1, 1'b1, 4'b0110}); n_fail++;
        end
        n_cmp++;
    endtask

    task automatic test_reset_mid_play();
        track_sel = 2'd1; key_play = 1'b1;
        step();
        if (o_state !== 3'd4) begin
            $display("FAIL mid_play_enter: got %0d want %0d", o_state, 4); n_fail++;
        end
        n_cmp++;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        if ({o_state, o_track_valid, o_player_en, o_i2c_start} !== {3'd0, 4'b0000, 1'b0, 1'b1}) begin
            $display("FAIL async_reset: got %b want %b", {o_state, o_track_valid, o_player_en, o_i2c_start}, {3'd0, 4'b0000, 1'b0, 1'b1}); n_fail++;
        end
        n_cmp++;
        @(posedge clk);
        #1;
        if (obs !== exp_vec()) begin
            $display("FAIL reset_held_vec: got %h want %h", obs, exp_vec()); n_fail++;
        end
        n_cmp++;
        rst = 1'b0;
        step();
        if (o_state !== 3'd1) begin
            $display("FAIL reinit: got %0d want %0d", o_state, 1); n_fail++;
        end
        n_cmp++;
    endtask

    task automatic test_random();
        logic [19:0] b;
        for (int n = 0; n < 800; n++) begin
            b = 20'(m_active) * REGION;
            key_stop  = ($urandom_range(0, 99) < 4);
            key_rec   = ($urandom_range(0, 99) < 10);
            key_play  = ($urandom_range(0, 99) < 14);
            track_sel = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       rec_addr = b;
                1:       rec_addr = b + (REGION - 20'd1);
                default: rec_addr = b + 20'($urandom_range(1, 300));
            endcase
            case ($urandom_range(0, 3))
                0:       play_addr = m_end[m_active];
                1:       play_addr = b;
                default: play_addr = b + 20'($urandom_range(0, 600));
            endcase
            step();
            if (obs !== exp_vec()) begin
                $display("FAIL random_vec n=%0d: got %h want %h", n, obs, exp_vec()); n_fail++;
            end
            n_cmp++;
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_record_stop();
        test_autostop();
        test_play();
        test_simultaneous();
        test_reset_mid_play();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
